uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Upstream scheduler for the 2-byte UART transmitter. Queues 16-bit words from producers in a
//  small FIFO and feeds them one at a time over the transmitter's data/en/done handshake.
//  Holds en for the whole transfer, releases it on done, then enforces an idle gap so no word
//  is sent twice. Runs in the 9600 Hz baud clock domain, same as the transmitter.
// PARAMETERS
//  DEPTH       4   FIFO entries (power of 2, >=2)
//  ADDR_W      2   log2(DEPTH)
//  GAP_CYCLES  2   cycles tx_en is held low between words (>=1)
//  TIMEOUT     32  max cycles in SEND waiting for tx_done (only with UART_TX_SCHED_TIMEOUT_EN)
// PORTS
//  clk_9k6hz  in   1         baud clock; all logic on posedge
//  rst_n      in   1         async active-low reset
//  wr_en      in   1         push wr_data this cycle
//  wr_data    in   16        word to send; bit 0 goes out first
//  full       out  1         level == DEPTH
//  empty      out  1         level == 0
//  level      out  ADDR_W+1  words queued (not counting the word in flight)
//  tx_data    out  16        to transmitter data; stable while tx_en=1
//  tx_en      out  1         to transmitter en
//  tx_done    in   1         from transmitter done
//  busy       out  1         state != IDLE
//  sent       out  1         1-cycle pulse: word completed
//  ovf        out  1         sticky: push while full (word dropped)
//  tmo        out  1         sticky: transfer timed out (0 when macro off)
// BEHAVIOUR
//  Reset (async, immediate): tx_en=0, tx_data=0, sent=0, ovf=0, tmo=0, level=0, empty=1,
//   full=0, busy=0, ptrs=0, state=IDLE. Reset mid-transfer drops tx_en at once; the word is lost.
//  FIFO: push when wr_en && !full; wr_en && full -> word dropped, ovf<=1, level unchanged.
//   Push and pop on the same edge -> level unchanged; a push into empty FIFO is poppable next cycle.
//   Pointers wrap modulo DEPTH.
//  FSM (registered outputs):
//   IDLE: if !empty -> tx_data<=head, pop, tx_en<=1, ->SEND. Else stay, tx_en=0.
//   SEND: hold tx_en=1, tx_data; cycle counter++. On tx_done==1 -> tx_en<=0, sent<=1 (one cycle),
//         gap_cnt<=GAP_CYCLES-1, ->GAP. tx_done in IDLE/GAP is ignored.
//   GAP:  tx_en=0; if gap_cnt==0 ->IDLE else gap_cnt--. Pushes accepted during all states.
//  Latency: word pushed into empty idle FIFO -> tx_en high 2 edges after push edge
//   (push edge; IDLE sees !empty next edge). Transmitter takes 21 cycles en-rise to done for
//   2 bytes, so per-word period = 21 + 1 + GAP_CYCLES cycles.
//  Transmitter samples en once more after done; the abort that causes is benign (tx stays 1)
//   and GAP guarantees the transmitter is back in IDLE before the next en rise.
// CONFIGURATION
//  `UART_TX_SCHED_TIMEOUT_EN defined: in SEND, if counter reaches TIMEOUT without tx_done ->
//   tx_en<=0, tmo<=1 (sticky), no sent pulse, ->GAP; word discarded, queue continues.
//  Not defined: no counter logic, SEND waits forever for tx_done, tmo tied 0.
// TESTING
//  1 push 16'hA55A into empty FIFO, model transmitter -> tx_en rises 2 cycles later, tx_data=A55A,
//    serial line shows 5A then A5 LSB-first, one sent pulse, tx_en low >=GAP_CYCLES, busy->0.
//  2 push 4 words back-to-back (1111,2222,3333,4444) -> full=1 after 4th push, sent in order,
//    exactly 4 sent pulses, never duplicated, level 4->3 on first pop.
//  3 push 5th word 5555 while full -> ovf=1 and stays 1, 5555 never appears on tx_data.
//  4 push and pop on same edge at level=2 -> level stays 2; wrap: 9 words over time, order kept.
//  5 assert rst_n=0 mid-SEND (cycle 10 of transfer) -> tx_en=0 immediately, level=0, ovf=0,
//    no sent pulse; after release, new push 0x0F0F sent normally.
//  6 macro on, transmitter stub never raises done -> tx_en drops at cycle TIMEOUT=32, tmo=1,
//    next queued word sent; macro off, same stub -> tx_en held indefinitely, tmo=0.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - producer and transmitter-side signal bundle for uart_tx_sched
interface uart_tx_sched_if #(
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [15:0]       wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic [15:0]       tx_data;
    logic              tx_en;
    logic              tx_done;
    logic              busy;
    logic              sent;
    logic              ovf;
    logic              tmo;

    modport slave (
        input  wr_en, wr_data, tx_done,
        output full, empty, level, tx_data, tx_en, busy, sent, ovf, tmo
    );

    modport master (
        output wr_en, wr_data, tx_done,
        input  full, empty, level, tx_data, tx_en, busy, sent, ovf, tmo
    );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - word FIFO plus en/done scheduler for the 2-byte UART transmitter
// Optional transfer timeout enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 32
) (
    input  logic               clk_9k6hz,
    input  logic               rst_n,
    uart_tx_sched_if.slave     s_if
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_ovf;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_tx_data;
    logic [15:0]       w_tx_data_nxt;
    logic              r_tx_en;
    logic              w_tx_en_nxt;
    logic              r_sent;
    logic              w_sent_nxt;
    logic [GW-1:0]     r_gap_cnt;
    logic [GW-1:0]     w_gap_cnt_nxt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int     TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     r_send_cnt;
    logic [TW-1:0]     w_send_cnt_nxt;
    logic              r_tmo;
    logic              w_tmo_nxt;
`else
    logic              w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = s_if.wr_en && !w_full;

    // Storage is not reset: pointers and level alone define what is valid.
    always_ff @(posedge clk_9k6hz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_if.wr_data;
        end
    end

    always_ff @(posedge clk_9k6hz or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (s_if.wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_data_nxt = r_tx_data;
        w_tx_en_nxt   = r_tx_en;
        w_sent_nxt    = 1'b0;
        w_gap_cnt_nxt = r_gap_cnt;
        w_pop         = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        w_send_cnt_nxt = r_send_cnt;
        w_tmo_nxt      = r_tmo;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tx_en_nxt = 1'b0;
                if (!w_empty) begin
                    w_tx_data_nxt = r_mem[r_rd_ptr];
                    w_pop         = 1'b1;
                    w_tx_en_nxt   = 1'b1;
                    w_state_nxt   = ST_SEND;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    w_send_cnt_nxt = '0;
`endif
                end
            end
            ST_SEND: begin
                w_tx_en_nxt = 1'b1;
                if (s_if.tx_done) begin
                    w_tx_en_nxt   = 1'b0;
                    w_sent_nxt    = 1'b1;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_state_nxt   = ST_GAP;
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                // A stuck transmitter costs exactly TIMEOUT cycles of en, then the word is dropped.
                else if (r_send_cnt == TW'(TIMEOUT - 1)) begin
                    w_tx_en_nxt   = 1'b0;
                    w_tmo_nxt     = 1'b1;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_state_nxt   = ST_GAP;
                end else begin
                    w_send_cnt_nxt = r_send_cnt + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                w_tx_en_nxt = 1'b0;
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_tx_en_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_9k6hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx_data <= '0;
            r_tx_en   <= 1'b0;
            r_sent    <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_en   <= w_tx_en_nxt;
            r_sent    <= w_sent_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_9k6hz or negedge rst_n) begin
        if (!rst_n) begin
            r_send_cnt <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_send_cnt <= w_send_cnt_nxt;
            r_tmo      <= w_tmo_nxt;
        end
    end
    assign s_if.tmo = r_tmo;
`else
    assign s_if.tmo = 1'b0;
`endif

    assign s_if.full    = w_full;
    assign s_if.empty   = w_empty;
    assign s_if.level   = r_level;
    assign s_if.tx_data = r_tx_data;
    assign s_if.tx_en   = r_tx_en;
    assign s_if.busy    = (r_state != ST_IDLE);
    assign s_if.sent    = r_sent;
    assign s_if.ovf     = r_ovf;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched with transmitter model and queue reference
module tb_uart_tx_sched;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 2;
    localparam int GAP     = 2;
    localparam int TMO     = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_sched #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_9k6hz (clk),
        .rst_n     (rst_n),
        .s_if      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: words accepted but not yet handed to the transmitter, plus sticky overflow.
    logic [15:0] model_q[$];
    bit          model_ovf = 1'b0;

    // Transmitter model state
    bit          stub_hang   = 1'b0;
    bit          stub_spur   = 1'b0;
    bit          stub_active = 1'b0;
    int          stub_cnt    = 0;
    logic [15:0] stub_word   = '0;
    logic        stub_done   = 1'b0;
    logic        line        = 1'b1;
    logic        line_bits[$];
    logic        last_bits[$];
    logic [15:0] got_q[$];
    bit          prev_en = 1'b0, prev_done = 1'b0, have_prev = 1'b0;
    int          low_len = 0, abort_len = 0, abort_cnt = 0, done_cnt = 0, sent_cnt = 0;
    logic [31:0] exp_w;

    assign bus.tx_done = stub_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input logic [15:0] w, input int k);
        int p;
        p = k % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[(k / 10) * 8 + p - 1];
    endfunction

    // Transmitter: start+8 data+stop per byte, done 21 cycles after en rises.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            stub_active = 1'b0; stub_done = 1'b0; stub_spur = 1'b0; line = 1'b1;
            prev_en = 1'b0; prev_done = 1'b0; have_prev = 1'b0; low_len = 0;
        end else begin
            chk("sent_pulse", 32'(bus.sent), 32'(prev_en & prev_done));
            if (bus.sent) sent_cnt++;
            stub_done = 1'b0;
            if (stub_active) begin
                if (!bus.tx_en) begin
                    stub_active = 1'b0; line = 1'b1;
                    abort_len = stub_cnt + 1; abort_cnt++;
                end else begin
                    chk("tx_data_hold", 32'(bus.tx_data), 32'(stub_word));
                    stub_cnt++;
                    if (stub_cnt < 20) begin
                        line = fbit(stub_word, stub_cnt);
                        line_bits.push_back(line);
                    end else if (stub_cnt == 20 && !stub_hang) begin
                        line = 1'b1; stub_done = 1'b1; stub_active = 1'b0;
                        got_q.push_back(stub_word); last_bits = line_bits; done_cnt++;
                    end
                end
            end else if (bus.tx_en && !prev_en) begin
                exp_w = (model_q.size() > 0) ? {16'h0, model_q.pop_front()} : 32'hDEAD_BEEF;
                chk("pop_order", 32'(bus.tx_data), exp_w);
                if (have_prev) chk("gap_len_ok", 32'(low_len >= GAP), 32'd1);
                stub_active = 1'b1; stub_cnt = 0; stub_word = bus.tx_data; have_prev = 1'b1;
                line = fbit(stub_word, 0);
                line_bits.delete(); line_bits.push_back(line);
            end else if (stub_spur) begin
                stub_done = 1'b1; stub_spur = 1'b0;
            end
            if (!bus.tx_en) low_len++; else low_len = 0;
            prev_en   = bus.tx_en;
            prev_done = stub_done;
        end
    end

    task automatic cycle(input bit we, input logic [15:0] d);
        @(negedge clk);
        chk("level", 32'(bus.level), 32'(model_q.size()));
        chk("empty", 32'(bus.empty), 32'(model_q.size() == 0));
        chk("full",  32'(bus.full),  32'(model_q.size() == DEPTH));
        chk("ovf",   32'(bus.ovf),   32'(model_ovf));
`ifndef UART_TX_SCHED_TIMEOUT_EN
        chk("tmo_off", 32'(bus.tmo), 32'd0);
`endif
        bus.wr_en   = we;
        bus.wr_data = d;
        if (we) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else model_ovf = 1'b1;
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_tx_en",   32'(bus.tx_en),   32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_sent",    32'(bus.sent),    32'd0);
        chk("rst_ovf",     32'(bus.ovf),     32'd0);
        chk("rst_tmo",     32'(bus.tmo),     32'd0);
        chk("rst_level",   32'(bus.level),   32'd0);
        chk("rst_empty",   32'(bus.empty),   32'd1);
        chk("rst_full",    32'(bus.full),    32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        model_q.delete(); model_ovf = 1'b0; stub_hang = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            cycle(1'b0, 16'h0);
            if (!bus.busy && bus.empty && !stub_active) break;
        end
        chk("drain_busy",  32'(bus.busy),  32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent_before, ab, hits;
        logic [7:0] by;
        logic [7:0] exp_by;
        bus.wr_en = 1'b0;
        bus.wr_data = 16'h0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;

        // 1: single word, latency and serial framing
        cycle(1'b1, 16'hA55A);
        cycle(1'b0, 16'h0);
        chk("lat_en_low", 32'(bus.tx_en), 32'd0);
        cycle(1'b0, 16'h0);
        chk("lat_en_high", 32'(bus.tx_en), 32'd1);
        chk("lat_data",    32'(bus.tx_data), 32'hA55A);
        chk("lat_busy",    32'(bus.busy), 32'd1);
        wait_idle(60);
        chk("t1_sent_cnt", 32'(sent_cnt), 32'd1);
        chk("t1_got", 32'(got_q.size() > 0 ? got_q[$] : 16'h0), 32'hA55A);
        chk("frame_len", 32'(last_bits.size()), 32'd20);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) by[i] = last_bits[b * 10 + 1 + i];
            exp_by = (b == 0) ? 8'h5A : 8'hA5;
            chk("start_bit",   32'(last_bits[b * 10]),     32'd0);
            chk("stop_bit",    32'(last_bits[b * 10 + 9]), 32'd1);
            chk("serial_byte", 32'(by), 32'(exp_by));
        end

        // 2/3: fill while a word is in flight, then overflow
        cycle(1'b1, 16'hBEEF);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0);
        cycle(1'b1, 16'h1111);
        cycle(1'b1, 16'h2222);
        cycle(1'b1, 16'h3333);
        cycle(1'b1, 16'h4444);
        cycle(1'b0, 16'h0);
        chk("t2_full", 32'(bus.full), 32'd1);
        cycle(1'b1, 16'h5555);
        cycle(1'b0, 16'h0);
        chk("t3_ovf", 32'(bus.ovf), 32'd1);
        wait_idle(200);
        chk("t3_ovf_sticky", 32'(bus.ovf), 32'd1);
        hits = 0;
        foreach (got_q[k]) if (got_q[k] == 16'h5555) hits++;
        chk("t3_no_5555", 32'(hits), 32'd0);
        chk("t2_sent_cnt", 32'(sent_cnt), 32'd6);

        // done while idle must be ignored
        sent_before = sent_cnt;
        @(negedge clk);
        stub_spur = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0);
        chk("spur_no_sent", 32'(sent_cnt), 32'(sent_before));
        chk("spur_idle",    32'(bus.busy), 32'd0);

        // 4: random traffic, light then heavy, exercising wrap and push/pop on one edge
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 11) == 0, 16'($urandom_range(0, 65535)));
        for (int i = 0; i < 60; i++)
            cycle($urandom_range(0, 1) == 1, 16'($urandom_range(0, 65535)));
        wait_idle(200);

        // 5: reset in the middle of a transfer
        cycle(1'b1, 16'h1234);
        cycle(1'b1, 16'h5678);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 16'h0);
            if (stub_active && stub_cnt == 10) break;
        end
        chk("t5_cycle10", 32'(stub_cnt), 32'd10);
        sent_before = sent_cnt;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        model_q.delete(); model_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0);
        chk("t5_no_sent", 32'(sent_cnt), 32'(sent_before));
        cycle(1'b1, 16'h0F0F);
        wait_idle(60);
        chk("t5_got", 32'(got_q.size() > 0 ? got_q[$] : 16'h0), 32'h0F0F);

        // 6: transmitter never finishes
        stub_hang = 1'b1;
        ab = abort_cnt;
        cycle(1'b1, 16'hC0DE);
        cycle(1'b1, 16'hD00D);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        for (int i = 0; i < 80; i++) begin
            cycle(1'b0, 16'h0);
            if (!bus.tx_en && abort_cnt != ab) break;
        end
        chk("t6_abort_cnt", 32'(abort_cnt), 32'(ab + 1));
        chk("t6_en_len",    32'(abort_len), 32'(TMO));
        chk("t6_tmo",       32'(bus.tmo), 32'd1);
        stub_hang = 1'b0;
        wait_idle(80);
        chk("t6_next_word", 32'(got_q.size() > 0 ? got_q[$] : 16'h0), 32'hD00D);
        chk("t6_tmo_sticky", 32'(bus.tmo), 32'd1);
`else
        for (int i = 0; i < 60; i++) cycle(1'b0, 16'h0);
        chk("t6_en_held",  32'(bus.tx_en),   32'd1);
        chk("t6_data",     32'(bus.tx_data), 32'hC0DE);
        chk("t6_tmo_off",  32'(bus.tmo),     32'd0);
        chk("t6_no_abort", 32'(abort_cnt),   32'(ab));
        do_reset();
`endif

        chk("sent_vs_done", 32'(sent_cnt), 32'(done_cnt));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
